// File: rtl/puf_response_collector.sv
// Arbiter-PUF response collector: one bit per challenge, packed MSB-first into N-bit words.
// Optional RESP_MAJORITY_EN: 3-cycle sample window, 2-of-3 majority vote per bit.
module puf_response_collector #(
   parameter int unsigned N      = 32,
   parameter int unsigned SETTLE = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         chal_valid,
   output logic         chal_ready,
   input  logic         resp_bit,
   output logic [N-1:0] out_word,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [15:0]  word_count
);

   localparam int unsigned BW = $clog2(N);
   localparam int unsigned CW = $clog2(SETTLE + 1);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_SETTLE = 2'd1;
   localparam logic [1:0] S_SAMPLE = 2'd2;
   localparam logic [1:0] S_FULL   = 2'd3;

   logic [1:0]    state_q,      state_d;
   logic [CW-1:0] settle_q,     settle_d;
   logic [N-1:0]  shreg_q,      shreg_d;
   logic [BW-1:0] bit_cnt_q,    bit_cnt_d;
   logic [N-1:0]  out_word_q,   out_word_d;
   logic          out_valid_q,  out_valid_d;
   logic [15:0]   word_count_q, word_count_d;
   logic          chal_ready_q, chal_ready_d;
   logic          sample_done;
   logic          new_bit;
`ifdef RESP_MAJORITY_EN
   logic [1:0]    samp_q, samp_d;
   logic [1:0]    maj_q,  maj_d;
`endif

   // Next-state and datapath
   always_comb begin
      state_d      = state_q;
      settle_d     = settle_q;
      shreg_d      = shreg_q;
      bit_cnt_d    = bit_cnt_q;
      out_word_d   = out_word_q;
      out_valid_d  = out_valid_q;
      word_count_d = word_count_q;
`ifdef RESP_MAJORITY_EN
      samp_d       = samp_q;
      maj_d        = maj_q;
      sample_done  = (samp_q == 2'd2);
      new_bit      = (maj_q[0] & maj_q[1]) | (maj_q[0] & resp_bit) | (maj_q[1] & resp_bit);
`else
      sample_done  = 1'b1;
      new_bit      = resp_bit;
`endif

      case (state_q)
         S_IDLE: begin
            if (chal_valid) begin
               state_d  = S_SETTLE;
               settle_d = CW'(SETTLE - 1);
            end
         end
         S_SETTLE: begin
            if (settle_q == '0) begin
               state_d = S_SAMPLE;
`ifdef RESP_MAJORITY_EN
               samp_d  = 2'd0;
`endif
            end else begin
               settle_d = settle_q - CW'(1);
            end
         end
         S_SAMPLE: begin
`ifdef RESP_MAJORITY_EN
            // First two window cycles only capture; the vote happens on the third
            if (samp_q == 2'd0) maj_d[0] = resp_bit;
            if (samp_q == 2'd1) maj_d[1] = resp_bit;
            if (!sample_done) samp_d = samp_q + 2'd1;
`endif
            if (sample_done) begin
               shreg_d = {shreg_q[N-2:0], new_bit};
               if (bit_cnt_q == BW'(N - 1)) begin
                  state_d     = S_FULL;
                  out_word_d  = shreg_d;
                  out_valid_d = 1'b1;
                  bit_cnt_d   = '0;
               end else begin
                  bit_cnt_d = bit_cnt_q + BW'(1);
                  state_d   = S_IDLE;
               end
            end
         end
         S_FULL: begin
            if (out_valid_q && out_ready) begin
               out_valid_d  = 1'b0;
               word_count_d = word_count_q + 16'd1;
               state_d      = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      chal_ready_d = (state_d == S_IDLE);
   end

   // State registers; chal_ready stays low while reset is held
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= S_IDLE;
         settle_q     <= '0;
         shreg_q      <= '0;
         bit_cnt_q    <= '0;
         out_word_q   <= '0;
         out_valid_q  <= 1'b0;
         word_count_q <= 16'd0;
         chal_ready_q <= 1'b0;
`ifdef RESP_MAJORITY_EN
         samp_q       <= 2'd0;
         maj_q        <= 2'd0;
`endif
      end else begin
         state_q      <= state_d;
         settle_q     <= settle_d;
         shreg_q      <= shreg_d;
         bit_cnt_q    <= bit_cnt_d;
         out_word_q   <= out_word_d;
         out_valid_q  <= out_valid_d;
         word_count_q <= word_count_d;
         chal_ready_q <= chal_ready_d;
`ifdef RESP_MAJORITY_EN
         samp_q       <= samp_d;
         maj_q        <= maj_d;
`endif
      end
   end

   assign chal_ready = chal_ready_q;
   assign out_word   = out_word_q;
   assign out_valid  = out_valid_q;
   assign word_count = word_count_q;

endmodule

// File: tb/tb_puf_response_collector.sv
// Randomized bench for puf_response_collector against a bit-queue reference model.
module tb_puf_response_collector;

   localparam int unsigned N = 32;
   localparam int unsigned S = 4;
`ifdef RESP_MAJORITY_EN
   localparam int unsigned L = 3;
`else
   localparam int unsigned L = 1;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          chal_valid;
   logic          chal_ready;
   logic          resp_bit;
   logic [N-1:0]  out_word;
   logic          out_valid;
   logic          out_ready;
   logic [15:0]   word_count;

   int            total = 0;
   int            bad   = 0;
   logic [15:0]   exp_count;
   logic          hold_ready;
   bit            exp_bits[$];

   puf_response_collector #(.N(N), .SETTLE(S)) dut (
      .clk        (clk),
      .rst        (rst),
      .chal_valid (chal_valid),
      .chal_ready (chal_ready),
      .resp_bit   (resp_bit),
      .out_word   (out_word),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .word_count (word_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Word the spec says should appear: bits in arrival order, first one in the MSB
   function automatic logic [N-1:0] model_word();
      logic [N-1:0] w = '0;
      for (int i = 0; i < int'(N); i++) w[N-1-i] = exp_bits[i];
      return w;
   endfunction

   task automatic wait_ready();
      int n = 0;
      while (chal_ready !== 1'b1 && n < 64) begin
         @(negedge clk);
         n++;
      end
      if (chal_ready !== 1'b1) check("ready_timeout", 32'(chal_ready), 32'(1));
   endtask

   // One challenge; win[i] is resp_bit during sample-window cycle i, noise elsewhere
   task automatic send_bit(input logic [2:0] win);
      int   sum;
      logic b;
      wait_ready();
      chal_valid = 1'b1;
      resp_bit   = 1'($urandom);
      @(posedge clk);
      for (int k = 0; k < int'(S + L); k++) begin
         @(negedge clk);
         if (k == 0) check("busy_ready", 32'(chal_ready), 32'(0));
         chal_valid = 1'($urandom);
         out_ready  = 1'($urandom);
         resp_bit   = (k >= int'(S)) ? win[k-int'(S)] : 1'($urandom);
      end
      @(negedge clk);
      chal_valid = 1'b0;
      out_ready  = hold_ready;
      resp_bit   = 1'($urandom);
      sum = int'(win[0]) + int'(win[1]) + int'(win[2]);
      b   = (L == 3) ? 1'(sum >= 2) : win[0];
      exp_bits.push_back(b);
      if (exp_bits.size() == int'(N)) begin
         check("full_valid", 32'(out_valid), 32'(1));
         check("full_word", 32'(out_word), 32'(model_word()));
         check("full_ready", 32'(chal_ready), 32'(0));
      end else begin
         check("cadence_ready", 32'(chal_ready), 32'(1));
      end
   endtask

   task automatic send_word(input logic [N-1:0] pat, input int nbits);
      logic       b;
      logic [2:0] win;
      for (int i = 0; i < nbits; i++) begin
         b = pat[N-1-i];
         if (L == 3) begin
            win = {b, b, b};
            if ($urandom_range(0, 1) == 1) win[$urandom_range(0, 2)] = ~b;
         end else begin
            win = {2'($urandom), b};
         end
         send_bit(win);
      end
   endtask

   task automatic do_handoff();
      @(negedge clk);
      exp_count = exp_count + 16'd1;
      check("handoff_valid", 32'(out_valid), 32'(0));
      check("handoff_count", 32'(word_count), 32'(exp_count));
      check("handoff_ready", 32'(chal_ready), 32'(1));
      exp_bits.delete();
   endtask

   initial begin
      rst        = 1'b0;
      chal_valid = 1'b0;
      resp_bit   = 1'b0;
      out_ready  = 1'b0;
      hold_ready = 1'b1;
      exp_count  = 16'd0;

      repeat (3) @(negedge clk);
      check("rst_ready", 32'(chal_ready), 32'(0));
      check("rst_valid", 32'(out_valid), 32'(0));
      check("rst_word", 32'(out_word), 32'(0));
      check("rst_count", 32'(word_count), 32'(0));
      rst = 1'b1;
      @(negedge clk);
      check("post_rst_ready", 32'(chal_ready), 32'(1));
      check("post_rst_valid", 32'(out_valid), 32'(0));

      send_word(32'hA5A5F00F, 32);
      check("a5_word", 32'(out_word), 32'hA5A5F00F);
      do_handoff();
      check("a5_count", 32'(word_count), 32'(1));

      repeat (2) begin
         send_word(N'($urandom), 32);
         do_handoff();
      end

`ifdef RESP_MAJORITY_EN
      send_bit(3'b101);
      send_bit(3'b100);
      send_word(N'($urandom), 30);
      check("maj_top_bits", 32'(out_word[N-1 -: 2]), 32'(2'b10));
      do_handoff();
`endif

      // Backpressure in FULL with a pending challenge
      hold_ready = 1'b0;
      send_word(N'($urandom), 32);
      for (int c = 0; c < 10; c++) begin
         chal_valid = 1'b1;
         resp_bit   = 1'($urandom);
         @(negedge clk);
         check("bp_valid", 32'(out_valid), 32'(1));
         check("bp_word", 32'(out_word), 32'(model_word()));
         check("bp_ready", 32'(chal_ready), 32'(0));
         check("bp_count", 32'(word_count), 32'(exp_count));
      end
      chal_valid = 1'b0;
      out_ready  = 1'b1;
      hold_ready = 1'b1;
      do_handoff();

      // Asynchronous reset mid-word
      send_word(N'($urandom), 17);
      #2 rst = 1'b0;
      #1;
      check("mid_rst_ready", 32'(chal_ready), 32'(0));
      check("mid_rst_count", 32'(word_count), 32'(0));
      check("mid_rst_valid", 32'(out_valid), 32'(0));
      @(negedge clk);
      rst = 1'b1;
      exp_count = 16'd0;
      exp_bits.delete();
      @(negedge clk);
      check("mid_rel_ready", 32'(chal_ready), 32'(1));

      hold_ready = 1'b0;
      send_word({N{1'b1}}, 32);
      check("ones_word", 32'(out_word), 32'hFFFFFFFF);

      // Asynchronous reset while holding a full word
      #2 rst = 1'b0;
      #1;
      check("full_rst_valid", 32'(out_valid), 32'(0));
      check("full_rst_word", 32'(out_word), 32'(0));
      @(negedge clk);
      rst = 1'b1;
      exp_count  = 16'd0;
      exp_bits.delete();
      hold_ready = 1'b1;
      out_ready  = 1'b1;
      @(negedge clk);
      check("full_rel_ready", 32'(chal_ready), 32'(1));

      // word_count wrap
      force dut.word_count_q = 16'hFFFF;
      @(posedge clk);
      @(negedge clk);
      release dut.word_count_q;
      exp_count = 16'hFFFF;
      send_word(N'($urandom), 32);
      do_handoff();
      check("wrap_count", 32'(word_count), 32'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/puf_response_collector.md
PUF_RESPONSE_COLLECTOR -- requirements
Module: puf_response_collector

Interface
REQ-001 SHALL have parameter N, default 32: response word width in bits, N >= 2.
REQ-002 SHALL have parameter SETTLE, default 4: cycles from challenge accept to response sample, SETTLE >= 1.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port chal_valid  input  1  challenge generator has applied a new challenge to the arbiter PUF.
REQ-006 SHALL have port chal_ready  output  1  collector can accept a challenge.
REQ-007 SHALL have port resp_bit  input  1  arbiter PUF response, already synchronised to clk.
REQ-008 SHALL have port out_word  output  N  assembled response word; the first-sampled bit is in the MSB.
REQ-009 SHALL have port out_valid  output  1  out_word holds a complete word.
REQ-010 SHALL have port out_ready  input  1  consumer accepts out_word.
REQ-011 SHALL have port word_count  output  16  count of words handed off; wraps from 0xFFFF to 0x0000.

Function
REQ-012 SHALL implement FSM states: IDLE, SETTLE, SAMPLE, FULL.
REQ-013 SHALL drive chal_ready=1 only in IDLE.
REQ-014 IDLE: when chal_valid=1 at a clock edge, the block SHALL go to SETTLE and load the settle counter with SETTLE-1; chal_valid is ignored in all other states.
REQ-015 SETTLE: the counter SHALL decrement each cycle; when it is 0, the FSM SHALL go to SAMPLE, so the first sample is taken SETTLE cycles after the accept edge.
REQ-016 SAMPLE: the sampled bit b SHALL be shifted in as shreg <= {shreg[N-2:0], b}, and bit_cnt SHALL increment.
REQ-017 When the sample completes with bit_cnt==N-1, the FSM SHALL go to FULL, load out_word with the new shreg, set out_valid=1 and clear bit_cnt; otherwise it SHALL return to IDLE.
REQ-018 FULL: out_valid and out_word SHALL stay stable until out_valid&out_ready occurs at an edge.
REQ-019 On that edge the block SHALL clear out_valid, increment word_count by 1 (mod 2^16) and go to IDLE; chal_ready SHALL be 1 in the following cycle.
REQ-020 out_ready while out_valid=0 SHALL have no effect.
REQ-021 Any resp_bit changes outside the sample cycle(s) SHALL be ignored.
REQ-022 Throughput without the macro: one bit per SETTLE+2 cycles, measured from accept to the next chal_ready.

Reset
REQ-023 While rst=0 the block SHALL be in IDLE, with shreg=0, bit_cnt=0, settle counter=0, out_word=0, out_valid=0, word_count=0, and chal_ready=0.
REQ-024 Reset assertion SHALL act immediately, without a clock edge, in any state, including mid-word and in FULL; partial words are discarded.
REQ-025 After rst deasserts, chal_ready SHALL be 1 from the first clock edge onward.

Configuration
REQ-026 The macro SHALL be RESP_MAJORITY_EN.
REQ-027 When RESP_MAJORITY_EN is defined, SAMPLE SHALL last 3 cycles, capture resp_bit on each cycle, and shift in the 2-of-3 majority on the third cycle; throughput becomes SETTLE+4 cycles per bit.
REQ-028 When RESP_MAJORITY_EN is not defined, SAMPLE SHALL last 1 cycle and shift in resp_bit directly.

Verification
REQ-029 Reset sequence: hold rst=0, then release -> out_valid=0, word_count=0, out_word=0, and chal_ready=1 at the first edge.
REQ-030 Full word, N=32, SETTLE=4, no macro: 32 challenges with resp_bit pattern 0xA5A5_F00F (MSB first), out_ready=1 -> out_word=0xA5A5F00F, out_valid for 1 cycle, word_count=1; each bit sampled exactly 4 cycles after its accept.
REQ-031 Backpressure: out_ready=0 for 10 cycles in FULL while chal_valid=1 -> chal_ready=0, out_word stable, no bits absorbed; when out_ready rises -> word_count increments once.
REQ-032 Reset mid-operation: assert rst after 17 bits, release, then send 32 bits of all ones -> out_word=0xFFFFFFFF, with no leftover bits from the aborted word.
REQ-033 Majority (macro defined): resp_bit=1,0,1 across the sample window -> bit 1 shifted in; 0,0,1 -> bit 0; glitches during SETTLE do not affect the result.
REQ-034 Wrap-around: preload word_count 0xFFFF via 65535 handoffs (or force), do one more handoff -> word_count=0x0000.
